// File: rtl/zorro_dram_pkg.sv
//------------------------------------------------------------------------------
// zorro_dram_pkg: shared state encoding and default constants (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

package zorro_dram_pkg;

  localparam int BANKS_DEF   = 4;
  localparam int COLBITS_DEF = 10;
  localparam int REF_DIV_DEF = 108;
  localparam int PRE_CYC_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACC_RAS  = 3'd1,
    ST_ACC_CAS  = 3'd2,
    ST_ACC_HOLD = 3'd3,
    ST_PRECH    = 3'd4,
    ST_REF_CAS  = 3'd5,
    ST_REF_RAS  = 3'd6
  } state_t;

  // A single bank still needs a 1-bit select so the vectors stay legal.
  function automatic int bank_bits(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/zorro_refresh_timer.sv
//------------------------------------------------------------------------------
// zorro_refresh_timer: refresh interval divider, pending count, overflow flag (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module zorro_refresh_timer
  import zorro_dram_pkg::*;
#(
  parameter int REF_DIV = REF_DIV_DEF
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       i_ref_done,
  output logic [1:0] o_pending,
  output logic       o_ovf
);

  localparam int            CW       = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
  localparam logic [CW-1:0] c_RELOAD = CW'(REF_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_pend;
  logic          r_ovf;
  logic          w_tick;
  logic          w_dec;

  assign w_tick = (r_cnt == '0);
  assign w_dec  = i_ref_done && (r_pend != 2'd0);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_cnt  <= c_RELOAD;
      r_pend <= 2'd0;
      r_ovf  <= 1'b0;
    end else begin
      r_cnt <= w_tick ? c_RELOAD : (r_cnt - CW'(1));
      // A reload coinciding with a completed refresh leaves pending unchanged.
      unique case ({w_tick, w_dec})
        2'b10: begin
          if (r_pend == 2'd3) r_ovf  <= 1'b1;
          else                r_pend <= r_pend + 2'd1;
        end
        2'b01:   r_pend <= r_pend - 2'd1;
        default: r_pend <= r_pend;
      endcase
    end
  end

  assign o_pending = r_pend;
  assign o_ovf     = r_ovf;

endmodule

`default_nettype wire

// File: rtl/zorro_dram_ctrl.sv
//------------------------------------------------------------------------------
// zorro_dram_ctrl: 68000/Zorro DRAM controller with CBR refresh (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module zorro_dram_ctrl
  import zorro_dram_pkg::*;
#(
  parameter int BANKS   = BANKS_DEF,
  parameter int COLBITS = COLBITS_DEF,
  parameter int REF_DIV = REF_DIV_DEF,
  parameter int PRE_CYC = PRE_CYC_DEF
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               ASn,
  input  logic               UDSn,
  input  logic               LDSn,
  input  logic               RWn,
  input  logic               HIT,
  input  logic [23:1]        ADDR,
  output logic [COLBITS-1:0] MADDR,
  output logic [BANKS-1:0]   RASn,
  output logic               UCASn,
  output logic               LCASn,
  output logic               MEMWn,
  output logic               ACK,
  output logic               REF_OVF
);

  localparam int               BW         = bank_bits(BANKS);
  localparam logic [1:0]       c_PRE_LOAD = 2'(PRE_CYC - 1);
  localparam logic [BANKS-1:0] c_BANK_ONE = BANKS'(1);

  state_t             r_state;
  logic [BW-1:0]      r_bank;
  logic [1:0]         r_prech;
  logic [COLBITS-1:0] r_maddr;
  logic [BANKS-1:0]   r_rasn;
  logic               r_ucasn;
  logic               r_lcasn;
  logic               r_memwn;
  logic               r_ack;

  logic [31:0]        w_a32;
  logic [COLBITS-1:0] w_row;
  logic [COLBITS-1:0] w_col;
  logic [BW-1:0]      w_bank;
  logic [BANKS-1:0]   w_sel_n;
  logic [BANKS-1:0]   w_lat_sel_n;
  logic               w_req;
  logic               w_urgent;
  logic               w_ref_done;
  logic [1:0]         w_pending;
  logic               w_unused;

  // Byte-address view; bank bits beyond A23 read as zero for wide geometries.
  assign w_a32    = {8'd0, ADDR, 1'b0};
  assign w_row    = w_a32[2*COLBITS -: COLBITS];
  assign w_col    = w_a32[COLBITS -: COLBITS];
  assign w_unused = ^w_a32;

  generate
    if (BANKS == 1) begin : g_single_bank
      assign w_bank = '0;
    end else begin : g_multi_bank
      assign w_bank = w_a32[2*COLBITS+BW -: BW];
    end
  endgenerate

  assign w_sel_n     = ~(c_BANK_ONE << w_bank);
  assign w_lat_sel_n = ~(c_BANK_ONE << r_bank);
  assign w_req       = HIT && !ASn;
  assign w_urgent    = w_pending[1];
  assign w_ref_done  = (r_state == ST_REF_RAS);

  zorro_refresh_timer #(
    .REF_DIV (REF_DIV)
  ) u_refresh_timer (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .i_ref_done (w_ref_done),
    .o_pending  (w_pending),
    .o_ovf      (REF_OVF)
  );

  // Every DRAM strobe is computed for the next state and released by default,
  // so any exit from an active state drops them on the following edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= ST_IDLE;
      r_bank  <= '0;
      r_prech <= 2'd0;
      r_maddr <= '0;
      r_rasn  <= '1;
      r_ucasn <= 1'b1;
      r_lcasn <= 1'b1;
      r_memwn <= 1'b1;
      r_ack   <= 1'b0;
    end else begin
      r_rasn  <= '1;
      r_ucasn <= 1'b1;
      r_lcasn <= 1'b1;
      r_memwn <= 1'b1;
      r_ack   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_maddr <= w_row;
          if (w_req && !w_urgent) begin
            r_state <= ST_ACC_RAS;
            r_bank  <= w_bank;
            r_rasn  <= w_sel_n;
            r_memwn <= RWn;
          end else if (w_pending != 2'd0) begin
            r_state <= ST_REF_CAS;
            r_ucasn <= 1'b0;
            r_lcasn <= 1'b0;
          end
        end
        ST_ACC_RAS, ST_ACC_CAS, ST_ACC_HOLD: begin
          if (ASn) begin
            r_state <= ST_PRECH;
            r_prech <= c_PRE_LOAD;
          end else begin
            r_rasn  <= w_lat_sel_n;
            r_memwn <= RWn;
            r_ucasn <= UDSn;
            r_lcasn <= LDSn;
            r_ack   <= 1'b1;
            if (r_state == ST_ACC_RAS) begin
              r_state <= ST_ACC_CAS;
              r_maddr <= w_col;
            end else begin
              r_state <= ST_ACC_HOLD;
            end
          end
        end
        ST_PRECH: begin
          if (r_prech == 2'd0) r_state <= ST_IDLE;
          else                 r_prech <= r_prech - 2'd1;
        end
        ST_REF_CAS: begin
          r_state <= ST_REF_RAS;
          r_rasn  <= '0;
          r_ucasn <= 1'b0;
          r_lcasn <= 1'b0;
        end
        ST_REF_RAS: begin
          r_state <= ST_PRECH;
          r_prech <= c_PRE_LOAD;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign MADDR = r_maddr;
  assign RASn  = r_rasn;
  assign UCASn = r_ucasn;
  assign LCASn = r_lcasn;
  assign MEMWn = r_memwn;
  assign ACK   = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_zorro_dram_ctrl.sv
//------------------------------------------------------------------------------
// tb_zorro_dram_ctrl: randomized self-checking bench for zorro_dram_ctrl (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_zorro_dram_ctrl;

  localparam int BANKS   = 4;
  localparam int COLBITS = 10;
  localparam int REF_DIV = 108;
  localparam int PRE_CYC = 1;

  logic               CLK    = 1'b0;
  logic               RESETn = 1'b0;
  logic               ASn    = 1'b1;
  logic               UDSn   = 1'b1;
  logic               LDSn   = 1'b1;
  logic               RWn    = 1'b1;
  logic               HIT    = 1'b0;
  logic [23:1]        ADDR   = '0;
  logic [COLBITS-1:0] MADDR;
  logic [BANKS-1:0]   RASn;
  logic               UCASn, LCASn, MEMWn, ACK, REF_OVF;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  zorro_dram_ctrl #(
    .BANKS(BANKS), .COLBITS(COLBITS), .REF_DIV(REF_DIV), .PRE_CYC(PRE_CYC)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn),
    .HIT(HIT), .ADDR(ADDR), .MADDR(MADDR), .RASn(RASn), .UCASn(UCASn),
    .LCASn(LCASn), .MEMWn(MEMWn), .ACK(ACK), .REF_OVF(REF_OVF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Reference address decode written from the byte-address arithmetic.
  function automatic int m_byte(input logic [23:1] a);
    return int'({a, 1'b0});
  endfunction
  function automatic logic [COLBITS-1:0] m_row(input logic [23:1] a);
    return COLBITS'((m_byte(a) >> (COLBITS + 1)) % (1 << COLBITS));
  endfunction
  function automatic logic [COLBITS-1:0] m_col(input logic [23:1] a);
    return COLBITS'((m_byte(a) >> 1) % (1 << COLBITS));
  endfunction
  function automatic logic [BANKS-1:0] m_rasn(input logic [23:1] a);
    int b;
    b = (m_byte(a) >> (2 * COLBITS + 1)) % BANKS;
    return BANKS'(((1 << BANKS) - 1) - (1 << b));
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    edges++;
  endtask

  task automatic do_reset();
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RWn = 1'b1; HIT = 1'b0;
    #2 RESETn = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESETn = 1'b1;
    edges = 0;
  endtask

  task automatic test_reset();
    logic [23:1] a;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (RASn !== '1) begin errors++; $display("FAIL reset_rasn: got %b want all ones", RASn); end
    checks++; if ({UCASn, LCASn, MEMWn} !== 3'b111) begin errors++; $display("FAIL reset_cas_we: got %b want 111", {UCASn, LCASn, MEMWn}); end
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ACK); end
    checks++; if (MADDR !== '0) begin errors++; $display("FAIL reset_maddr: got %h want 0", MADDR); end
    checks++; if (REF_OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", REF_OVF); end
    RESETn = 1'b1;
    edges = 0;
    a = 23'($urandom);
    ADDR = a;
    step();
    checks++; if (MADDR !== m_row(a)) begin errors++; $display("FAIL idle_row: got %h want %h", MADDR, m_row(a)); end
    checks++; if (RASn !== '1 || ACK !== 1'b0) begin errors++; $display("FAIL idle_quiet: rasn %b ack %b want all ones / 0", RASn, ACK); end
  endtask

  task automatic test_read();
    logic [23:1] a;
    logic [23:0] ex;
    do_reset();
    ex = 24'h412345;
    for (int n = 0; n < 5; n++) begin
      a = (n == 0) ? ex[23:1] : 23'($urandom);
      ADDR = a; HIT = 1'b1; RWn = 1'b1; UDSn = 1'b0; LDSn = 1'b0; ASn = 1'b0;
      step();
      checks++; if (RASn !== m_rasn(a) || ACK !== 1'b0 || {UCASn, LCASn} !== 2'b11) begin
        errors++; $display("FAIL read_ras: rasn %b ack %b cas %b want %b 0 11", RASn, ACK, {UCASn, LCASn}, m_rasn(a));
      end
      step();
      checks++; if (MADDR !== m_col(a)) begin errors++; $display("FAIL read_col: got %h want %h", MADDR, m_col(a)); end
      checks++; if (ACK !== 1'b1 || {UCASn, LCASn, MEMWn} !== 3'b001 || RASn !== m_rasn(a)) begin
        errors++; $display("FAIL read_cas: ack %b cas_we %b rasn %b want 1 001 %b", ACK, {UCASn, LCASn, MEMWn}, RASn, m_rasn(a));
      end
      repeat ($urandom_range(0, 2)) begin
        step();
        checks++; if (ACK !== 1'b1 || RASn !== m_rasn(a)) begin errors++; $display("FAIL read_hold: ack %b rasn %b want 1 %b", ACK, RASn, m_rasn(a)); end
      end
      ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
      step();
      checks++; if (RASn !== '1 || {UCASn, LCASn, MEMWn, ACK} !== 4'b1110) begin
        errors++; $display("FAIL read_release: rasn %b cas_we_ack %b want all ones 1110", RASn, {UCASn, LCASn, MEMWn, ACK});
      end
      repeat (PRE_CYC + 1) step();
      checks++; if (MADDR !== m_row(a)) begin errors++; $display("FAIL read_idle_row: got %h want %h", MADDR, m_row(a)); end
    end
    HIT = 1'b0; ASn = 1'b0;
    repeat (3) begin
      step();
      checks++; if (RASn !== '1 || ACK !== 1'b0) begin errors++; $display("FAIL nohit_quiet: rasn %b ack %b want all ones 0", RASn, ACK); end
    end
    ASn = 1'b1;
  endtask

  task automatic test_write();
    logic [23:1] a;
    int du, dl;
    logic eu, el;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      a = 23'($urandom);
      du = (n == 0) ? 1 : int'($urandom_range(1, 4));
      dl = (n == 0) ? 1 : int'($urandom_range(1, 4));
      ADDR = a; HIT = 1'b1; RWn = 1'b0; UDSn = 1'b1; LDSn = 1'b1; ASn = 1'b0;
      for (int k = 0; k < 5; k++) begin
        step();
        eu = !(k >= 1 && k >= du);
        el = !(k >= 1 && k >= dl);
        checks++; if ({UCASn, LCASn} !== {eu, el} || MEMWn !== 1'b0 || ACK !== (k >= 1) || RASn !== m_rasn(a)) begin
          errors++; $display("FAIL write_k%0d: cas %b we %b ack %b rasn %b want %b 0 %b %b",
                             k, {UCASn, LCASn}, MEMWn, ACK, RASn, {eu, el}, (k >= 1), m_rasn(a));
        end
        if (k + 1 >= du) UDSn = 1'b0;
        if (k + 1 >= dl) LDSn = 1'b0;
      end
      ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RWn = 1'b1;
      step();
      checks++; if ({UCASn, LCASn, MEMWn, ACK} !== 4'b1110 || RASn !== '1) begin
        errors++; $display("FAIL write_release: cas_we_ack %b rasn %b want 1110 all ones", {UCASn, LCASn, MEMWn, ACK}, RASn);
      end
      repeat (PRE_CYC + 1) step();
    end
  endtask

  task automatic test_abort();
    logic [23:1] a, b;
    int s;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      s = (n == 0) ? 0 : int'($urandom_range(0, 2));
      a = 23'($urandom);
      ADDR = a; HIT = 1'b1; RWn = 1'($urandom); UDSn = 1'b0; LDSn = 1'b0; ASn = 1'b0;
      step();
      repeat (s) step();
      ASn = 1'b1;
      step();
      checks++; if (RASn !== '1 || {UCASn, LCASn, MEMWn, ACK} !== 4'b1110) begin
        errors++; $display("FAIL abort_s%0d: rasn %b cas_we_ack %b want all ones 1110", s, RASn, {UCASn, LCASn, MEMWn, ACK});
      end
      b = 23'($urandom);
      ADDR = b; ASn = 1'b0;
      for (int k = 0; k < PRE_CYC; k++) begin
        step();
        checks++; if (RASn !== '1) begin errors++; $display("FAIL abort_prech: rasn %b want all ones", RASn); end
      end
      step();
      checks++; if (RASn !== m_rasn(b) || ACK !== 1'b0) begin
        errors++; $display("FAIL abort_next_ras: rasn %b ack %b want %b 0", RASn, ACK, m_rasn(b));
      end
      ASn = 1'b1;
      repeat (PRE_CYC + 2) step();
    end
  endtask

  task automatic test_refresh_idle();
    logic [BANKS+2:0] exp_v;
    int refs;
    refs = 0;
    do_reset();
    ADDR = 23'($urandom);
    for (int k = 1; k <= REF_DIV + 8; k++) begin
      step();
      if (k == REF_DIV + 1)      exp_v = {{BANKS{1'b1}}, 3'b001};
      else if (k == REF_DIV + 2) exp_v = {{BANKS{1'b0}}, 3'b001};
      else                       exp_v = {{BANKS{1'b1}}, 3'b111};
      if (RASn === '0) refs++;
      checks++; if ({RASn, UCASn, LCASn, MEMWn} !== exp_v) begin
        errors++; $display("FAIL refresh_idle_c%0d: rasn_cas_we %b want %b", k, {RASn, UCASn, LCASn, MEMWn}, exp_v);
      end
    end
    checks++; if (refs != 1) begin errors++; $display("FAIL refresh_idle_count: got %0d want 1", refs); end
    checks++; if (REF_OVF !== 1'b0) begin errors++; $display("FAIL refresh_idle_ovf: got %b want 0", REF_OVF); end
  endtask

  task automatic test_back_to_back();
    logic [23:1] a;
    int ph, wait_n, hold_n, refs, guard;
    logic timed_out;
    do_reset();
    refs = 0; ph = 0; wait_n = 0; hold_n = 0; timed_out = 1'b0;
    a = 23'($urandom);
    ADDR = a; HIT = 1'b1; RWn = 1'($urandom); UDSn = 1'b0; LDSn = 1'b0; ASn = 1'b0;
    while (edges < 3 * REF_DIV && !timed_out) begin
      step();
      if (RASn === '1 && UCASn === 1'b0 && LCASn === 1'b0) begin
        checks++; if (((edges - 1) / REF_DIV) - refs < 2) begin
          errors++; $display("FAIL b2b_ref_not_urgent: pending %0d want >=2 at edge %0d", ((edges - 1) / REF_DIV) - refs, edges);
        end
      end
      if (RASn === '0) begin
        refs++;
        checks++; if (MEMWn !== 1'b1) begin errors++; $display("FAIL b2b_ref_we: got %b want 1", MEMWn); end
      end
      if (ACK === 1'b1) begin
        checks++; if (RASn !== m_rasn(a) || MEMWn !== RWn) begin
          errors++; $display("FAIL b2b_access: rasn %b we %b want %b %b", RASn, MEMWn, m_rasn(a), RWn);
        end
      end
      case (ph)
        0: begin
          if (ACK === 1'b1) begin
            checks++;
            hold_n = int'($urandom_range(0, 2));
            ph = 1;
          end else begin
            wait_n++;
            if (wait_n > 20) begin
              checks++; errors++; timed_out = 1'b1;
              $display("FAIL b2b_ack_timeout: ack %b after %0d cycles want 1", ACK, wait_n);
            end
          end
          if (ph == 1 && hold_n == 0) begin ASn = 1'b1; ph = 2; end
        end
        1: begin
          if (hold_n <= 1) begin ASn = 1'b1; ph = 2; end
          else hold_n--;
        end
        default: begin
          a = 23'($urandom);
          ADDR = a; RWn = 1'($urandom); ASn = 1'b0;
          ph = 0; wait_n = 0;
        end
      endcase
    end
    ASn = 1'b1; HIT = 1'b0; RWn = 1'b1;
    guard = 0;
    while ((edges % REF_DIV) != 20 && guard < 2 * REF_DIV) begin
      step();
      guard++;
      if (RASn === '0) refs++;
    end
    checks++; if (refs != edges / REF_DIV) begin errors++; $display("FAIL b2b_ref_count: got %0d want %0d", refs, edges / REF_DIV); end
    checks++; if (REF_OVF !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", REF_OVF); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ADDR = 23'($urandom); HIT = 1'b1; RWn = 1'b0; UDSn = 1'b0; LDSn = 1'b0; ASn = 1'b0;
    repeat (3) step();
    checks++; if (ACK !== 1'b1 || UCASn !== 1'b0) begin errors++; $display("FAIL midreset_pre: ack %b ucas %b want 1 0", ACK, UCASn); end
    #2 RESETn = 1'b0;
    #1;
    checks++; if (RASn !== '1 || {UCASn, LCASn, MEMWn} !== 3'b111) begin
      errors++; $display("FAIL midreset_strobes: rasn %b cas_we %b want all ones 111", RASn, {UCASn, LCASn, MEMWn});
    end
    checks++; if (ACK !== 1'b0 || REF_OVF !== 1'b0 || MADDR !== '0) begin
      errors++; $display("FAIL midreset_state: ack %b ovf %b maddr %h want 0 0 0", ACK, REF_OVF, MADDR);
    end
    ASn = 1'b1; HIT = 1'b0;
    #4 RESETn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_abort();
    test_refresh_idle();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
